mc_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the integer/FP register datapath. It detects load-use and multi-cycle-unit (FPU divide/sqrt, MDU divide) hazards at the ID stage and stalls fetch/decode, inserting bubbles into EX. It also launches and tracks the single outstanding multi-cycle operation and arbitrates the shared register-file write port between that unit and the MEM/WB pipeline register. It sits beside the EX-stage forwarding muxes and covers the hazards that forwarding cannot resolve.

---
 rtl/mc_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_hazard_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// mc_hazard_ctrl
//
// Hazard and sequencing controller for the integer/FP register datapath.
// It detects, at the ID stage, the hazards that EX-stage forwarding cannot
// resolve, and stalls fetch/decode while inserting a bubble into EX:
//   - load-use against the load currently in EX;
//   - RAW / WAW against the register tagged by the outstanding multi-cycle op;
//   - structural: a second multi-cycle op while the unit is still occupied.
// It also launches the single outstanding multi-cycle operation (FPU div/sqrt,
// MDU div), counts down its latency, and arbitrates the shared register-file
// write port between that unit and the MEM/WB pipeline register.
//
// Ports
//   clk_i, reset_i       core clock, asynchronous active-low reset
//   id_valid_i           ID holds a valid instruction
//   id_rs{1,2,3}_i       ID source register indices
//   id_use_i[2:0]        source use flags   ([2]=rs3 [1]=rs2 [0]=rs1)
//   id_bank_i[2:0]       source banks, 1=FP ([2]=rs3 [1]=rs2 [0]=rs1)
//   id_rd_i, id_rd_bank_i ID destination index / bank
//   id_wb_i              ID instruction writes rd
//   id_mc_op_i           ID instruction is a multi-cycle op
//   id_mc_lat_i          latency of that op, 1..31 cycles
//   ex_rd_i, ex_rd_bank_i EX destination index / bank
//   ex_load_i            EX holds a load writing ex_rd_i
//   memwb_wb_i           MEM/WB wants the write port this cycle
//   stall_o / bubble_o   freeze PC + IF/ID / load NOP into ID/EX
//   mc_start_o           one-cycle launch pulse to the multi-cycle unit
//   mc_wb_grant_o        unit result owns the write port this cycle
//   wb_freeze_o          hold MEM/WB (its write is deferred one cycle)
//   mc_busy_o            an operation is outstanding
// -----------------------------------------------------------------------------
module mc_hazard_ctrl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] id_rs3_i,
    input  logic [2:0] id_use_i,
    input  logic [2:0] id_bank_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_rd_bank_i,
    input  logic       id_wb_i,
    input  logic       id_mc_op_i,
    input  logic [4:0] id_mc_lat_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_rd_bank_i,
    input  logic       ex_load_i,
    input  logic       memwb_wb_i,
    output logic       stall_o,
    output logic       bubble_o,
    output logic       mc_start_o,
    output logic       mc_wb_grant_o,
    output logic       wb_freeze_o,
    output logic       mc_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e     state_q,     state_d;
    logic [4:0] cnt_q,       cnt_d;
    logic       pend_v_q,    pend_v_d;
    logic [4:0] pend_rd_q,   pend_rd_d;
    logic       pend_bank_q, pend_bank_d;

    // Same bank and same index; integer x0 is hardwired and never a dependency,
    // whereas FP f0 is an ordinary register.
    function automatic logic reg_match(input logic [4:0] a_idx, input logic a_bank,
                                       input logic [4:0] b_idx, input logic b_bank);
        return (a_idx == b_idx) && (a_bank == b_bank) && (a_bank || (a_idx != 5'd0));
    endfunction

    // ---------------------------------------------------------------- hazards
    logic [2:0] ld_hit;
    logic [2:0] raw_hit;
    logic       waw_hit;
    logic       structural;
    logic       hazard;

    // NOTE: every signal driven in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        ld_hit[0]  = id_use_i[0] && reg_match(id_rs1_i, id_bank_i[0], ex_rd_i, ex_rd_bank_i);
        ld_hit[1]  = id_use_i[1] && reg_match(id_rs2_i, id_bank_i[1], ex_rd_i, ex_rd_bank_i);
        ld_hit[2]  = id_use_i[2] && reg_match(id_rs3_i, id_bank_i[2], ex_rd_i, ex_rd_bank_i);
        raw_hit[0] = id_use_i[0] && reg_match(id_rs1_i, id_bank_i[0], pend_rd_q, pend_bank_q);
        raw_hit[1] = id_use_i[1] && reg_match(id_rs2_i, id_bank_i[1], pend_rd_q, pend_bank_q);
        raw_hit[2] = id_use_i[2] && reg_match(id_rs3_i, id_bank_i[2], pend_rd_q, pend_bank_q);
        waw_hit    = id_wb_i && reg_match(id_rd_i, id_rd_bank_i, pend_rd_q, pend_bank_q);
        structural = id_mc_op_i && (state_q != S_IDLE);
        hazard     = id_valid_i && (structural
                                    || (ex_load_i && (|ld_hit))
                                    || (pend_v_q && ((|raw_hit) || waw_hit)));
    end

    // The combinational ID-side outputs are forced low while reset is held so
    // that every output reads 0 during reset regardless of the ID/EX inputs.
    assign stall_o    = reset_i && hazard;
    assign bubble_o   = stall_o;
    assign mc_start_o = reset_i && id_valid_i && id_mc_op_i && !hazard;
    assign mc_busy_o  = (state_q != S_IDLE);

    // -------------------------------------------------- sequencer next state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_v_d      = pend_v_q;
        pend_rd_d     = pend_rd_q;
        pend_bank_d   = pend_bank_q;
        mc_wb_grant_o = 1'b0;
        wb_freeze_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (mc_start_o) begin
                    state_d     = S_BUSY;
                    cnt_d       = id_mc_lat_i;
                    pend_v_d    = id_rd_bank_i || (id_rd_i != 5'd0);
                    pend_rd_d   = id_rd_i;
                    pend_bank_d = id_rd_bank_i;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 5'd1;
                // <= rather than == so an out-of-range latency of 0 still
                // completes instead of wrapping through 31 more cycles.
                if (cnt_q <= 5'd1) begin
                    if (memwb_wb_i) begin
                        // Pipeline keeps the port this cycle; result waits.
                        state_d = S_HOLD;
                    end else begin
                        mc_wb_grant_o = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                mc_wb_grant_o = 1'b1;
                wb_freeze_o   = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The result is in the register file after the grant cycle, so the
        // tag can drop and dependent instructions release the next cycle.
        if (mc_wb_grant_o) begin
            pend_v_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            pend_v_q    <= 1'b0;
            pend_rd_q   <= 5'd0;
            pend_bank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_v_q    <= pend_v_d;
            pend_rd_q   <= pend_rd_d;
            pend_bank_q <= pend_bank_d;
        end
    end

endmodule

// File: tb/tb_mc_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_hazard_ctrl
//
// Self-checking bench for mc_hazard_ctrl. The reference model tracks the
// outstanding operation as (launch cycle, latency, deferred flag, tag) and
// derives every expected output from absolute cycle arithmetic: grant at
// launch+L when the port is free, else at launch+L+1 together with the freeze.
// Output vector layout: {stall, bubble, start, grant, freeze, busy}.
// -----------------------------------------------------------------------------
module tb_mc_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rs3_i;
    logic [2:0] id_use_i, id_bank_i;
    logic [4:0] id_rd_i;
    logic       id_rd_bank_i, id_wb_i, id_mc_op_i;
    logic [4:0] id_mc_lat_i;
    logic [4:0] ex_rd_i;
    logic       ex_rd_bank_i, ex_load_i, memwb_wb_i;
    logic       stall_o, bubble_o, mc_start_o, mc_wb_grant_o, wb_freeze_o, mc_busy_o;

    always #5 clk = ~clk;

    mc_hazard_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs3_i      (id_rs3_i),
        .id_use_i      (id_use_i),
        .id_bank_i     (id_bank_i),
        .id_rd_i       (id_rd_i),
        .id_rd_bank_i  (id_rd_bank_i),
        .id_wb_i       (id_wb_i),
        .id_mc_op_i    (id_mc_op_i),
        .id_mc_lat_i   (id_mc_lat_i),
        .ex_rd_i       (ex_rd_i),
        .ex_rd_bank_i  (ex_rd_bank_i),
        .ex_load_i     (ex_load_i),
        .memwb_wb_i    (memwb_wb_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .mc_start_o    (mc_start_o),
        .mc_wb_grant_o (mc_wb_grant_o),
        .wb_freeze_o   (wb_freeze_o),
        .mc_busy_o     (mc_busy_o)
    );

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------ model state
    int         cyc      = 0;
    bit         m_active = 1'b0;
    bit         m_defer  = 1'b0;
    int         m_launch = 0;
    int         m_lat    = 0;
    bit         m_tag_v  = 1'b0;
    logic [4:0] m_tag_rd = '0;
    bit         m_tag_bank = 1'b0;

    logic [5:0] obs_vec, exp_vec;

    function automatic bit same_reg(input logic [4:0] a, input bit ab,
                                    input logic [4:0] b, input bit bb);
        if (ab != bb || a != b) return 1'b0;
        return ab || (a != 5'd0);
    endfunction

    function automatic logic [5:0] model_outputs();
        logic [4:0] src [3];
        bit ld, raw, waw, strct, stall, start, grant, freeze;
        if (!reset_i) return 6'b0;
        src[0] = id_rs1_i;
        src[1] = id_rs2_i;
        src[2] = id_rs3_i;
        ld  = 1'b0;
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (id_use_i[i] && ex_load_i && same_reg(src[i], id_bank_i[i], ex_rd_i, ex_rd_bank_i))
                ld = 1'b1;
            if (id_use_i[i] && m_active && m_tag_v && same_reg(src[i], id_bank_i[i], m_tag_rd, m_tag_bank))
                raw = 1'b1;
        end
        waw    = id_wb_i && m_active && m_tag_v && same_reg(id_rd_i, id_rd_bank_i, m_tag_rd, m_tag_bank);
        strct  = id_mc_op_i && m_active;
        stall  = id_valid_i && (ld || raw || waw || strct);
        start  = id_valid_i && id_mc_op_i && !stall;
        grant  = m_active && ((cyc == m_launch + m_lat && !memwb_wb_i)
                              || (cyc == m_launch + m_lat + 1 && m_defer));
        freeze = m_active && m_defer && (cyc == m_launch + m_lat + 1);
        return {stall, stall, start, grant, freeze, m_active};
    endfunction

    task automatic model_commit();
        logic [5:0] e;
        e = model_outputs();
        if (reset_i) begin
            if (e[2]) m_active = 1'b0;
            if (m_active && cyc == m_launch + m_lat && memwb_wb_i) m_defer = 1'b1;
            if (e[3]) begin
                m_active   = 1'b1;
                m_defer    = 1'b0;
                m_launch   = cyc;
                m_lat      = int'(id_mc_lat_i);
                m_tag_rd   = id_rd_i;
                m_tag_bank = id_rd_bank_i;
                m_tag_v    = id_rd_bank_i || (id_rd_i != 5'd0);
            end
        end else begin
            m_active = 1'b0;
            m_defer  = 1'b0;
        end
        cyc++;
    endtask

    // Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
    task automatic sample();
        @(negedge clk);
        obs_vec = {stall_o, bubble_o, mc_start_o, mc_wb_grant_o, wb_freeze_o, mc_busy_o};
        exp_vec = model_outputs();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i   = 1'b0;
        id_rs1_i     = '0;
        id_rs2_i     = '0;
        id_rs3_i     = '0;
        id_use_i     = '0;
        id_bank_i    = '0;
        id_rd_i      = '0;
        id_rd_bank_i = 1'b0;
        id_wb_i      = 1'b0;
        id_mc_op_i   = 1'b0;
        id_mc_lat_i  = '0;
        ex_rd_i      = '0;
        ex_rd_bank_i = 1'b0;
        ex_load_i    = 1'b0;
        memwb_wb_i   = 1'b0;
    endtask

    task automatic set_mc(input logic [4:0] rd, input logic bank, input logic [4:0] lat);
        idle_inputs();
        id_valid_i   = 1'b1;
        id_mc_op_i   = 1'b1;
        id_wb_i      = 1'b1;
        id_rd_i      = rd;
        id_rd_bank_i = bank;
        id_mc_lat_i  = lat;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        // Hazard-provoking inputs while reset is held: outputs must stay 0.
        set_mc(5'd4, 1'b0, 5'd3);
        ex_load_i = 1'b1;
        ex_rd_i   = 5'd9;
        id_use_i  = 3'b001;
        id_rs1_i  = 5'd9;
        sample();
        checks++;
        if (obs_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs_vec, 6'b0);
        end
        advance();
        reset_i = 1'b1;
        idle_inputs();
        sample();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs_vec, exp_vec);
        end
        advance();
    endtask

    task automatic test_load_use();
        // {ex_rd, ex_bank, use, rs1, rs2, rs3, bank, expect stall}
        logic [4:0] rd_t   [6] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7, 5'd0};
        logic       rb_t   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] use_t  [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b101, 3'b010};
        logic [4:0] rs1_t  [6] = '{5'd5, 5'd5, 5'd0, 5'd1, 5'd1, 5'd3};
        logic [4:0] rs2_t  [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0};
        logic [4:0] rs3_t  [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd2, 5'd0};
        logic [2:0] bank_t [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
        logic       exp_st [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            id_valid_i   = 1'b1;
            ex_load_i    = 1'b1;
            ex_rd_i      = rd_t[i];
            ex_rd_bank_i = rb_t[i];
            id_use_i     = use_t[i];
            id_rs1_i     = rs1_t[i];
            id_rs2_i     = rs2_t[i];
            id_rs3_i     = rs3_t[i];
            id_bank_i    = bank_t[i];
            sample();
            checks++;
            if (obs_vec !== exp_vec || obs_vec[5] !== exp_st[i] || obs_vec[4] !== exp_st[i]) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b exp=%b stall_exp=%b", i, obs_vec, exp_vec, exp_st[i]);
            end
            advance();
            // Load has moved to MEM: the same ID instruction must not stall.
            ex_load_i = 1'b0;
            sample();
            checks++;
            if (obs_vec !== exp_vec || obs_vec[5] !== 1'b0) begin
                errors++;
                $display("FAIL load_use_release[%0d] got=%b exp=%b", i, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_launch();
        int t, grant_at, start_at, busy_n;
        grant_at = -1;
        start_at = -1;
        busy_n   = 0;
        set_mc(5'd3, 1'b1, 5'd4);
        t = cyc;
        for (int k = 0; k < 7; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL launch cyc=+%0d got=%b exp=%b", cyc - t, obs_vec, exp_vec);
            end
            if (obs_vec[3]) start_at = cyc;
            if (obs_vec[2]) grant_at = cyc;
            if (obs_vec[0]) busy_n++;
            advance();
            idle_inputs();
        end
        checks++;
        if (start_at !== t || grant_at !== t + 4 || busy_n !== 4) begin
            errors++;
            $display("FAIL launch_timing start=%0d grant=%0d busy=%0d exp start=%0d grant=%0d busy=4",
                     start_at, grant_at, busy_n, t, t + 4);
        end
    endtask

    task automatic test_raw();
        int t, last_stall, int_stalls;
        last_stall = -1;
        int_stalls = 0;
        set_mc(5'd3, 1'b1, 5'd4);
        t = cyc;
        sample();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL raw_launch got=%b exp=%b", obs_vec, exp_vec);
        end
        advance();
        for (int k = 1; k <= 6; k++) begin
            idle_inputs();
            id_valid_i = 1'b1;
            id_use_i   = 3'b010;
            id_rs2_i   = 5'd3;
            id_bank_i  = (k <= 2) ? 3'b000 : 3'b010;  // x3 first, then f3
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL raw cyc=+%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[5] && k <= 2) int_stalls++;
            if (obs_vec[5]) last_stall = cyc;
            advance();
        end
        idle_inputs();
        checks++;
        if (last_stall !== t + 4 || int_stalls !== 0) begin
            errors++;
            $display("FAIL raw_release last_stall=%0d int_stalls=%0d exp last_stall=%0d int_stalls=0",
                     last_stall, int_stalls, t + 4);
        end
    endtask

    task automatic test_port_conflict();
        int t, grant_at, freeze_at, idle_at;
        grant_at  = -1;
        freeze_at = -1;
        idle_at   = -1;
        set_mc(5'd3, 1'b1, 5'd4);
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            memwb_wb_i = (cyc == t + 4);
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL port_conflict cyc=+%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[2] && grant_at < 0) grant_at = cyc;
            if (obs_vec[1] && freeze_at < 0) freeze_at = cyc;
            if (k > 0 && !obs_vec[0] && idle_at < 0) idle_at = cyc;
            advance();
            idle_inputs();
        end
        checks++;
        if (grant_at !== t + 5 || freeze_at !== t + 5 || idle_at !== t + 6) begin
            errors++;
            $display("FAIL port_conflict_timing grant=%0d freeze=%0d idle=%0d exp %0d/%0d/%0d",
                     grant_at, freeze_at, idle_at, t + 5, t + 5, t + 6);
        end
    endtask

    task automatic test_structural_waw();
        int t, s, last_stall;
        s = -1;
        last_stall = -1;
        set_mc(5'd3, 1'b1, 5'd3);
        t = cyc;
        sample();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL struct_launch got=%b exp=%b", obs_vec, exp_vec);
        end
        advance();
        // Second multi-cycle op waits in ID until the first is granted.
        set_mc(5'd7, 1'b1, 5'd2);
        for (int k = 0; k < 8 && s < 0; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL structural k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[3]) s = cyc;
            advance();
        end
        // Plain (non-mc) write to the pending f7.
        idle_inputs();
        id_valid_i   = 1'b1;
        id_wb_i      = 1'b1;
        id_rd_i      = 5'd7;
        id_rd_bank_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL waw k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[5]) last_stall = cyc;
            advance();
        end
        idle_inputs();
        checks++;
        if (s !== t + 4 || last_stall !== t + 6) begin
            errors++;
            $display("FAIL struct_waw_timing start=%0d waw_last_stall=%0d exp %0d/%0d",
                     s, last_stall, t + 4, t + 6);
        end
    endtask

    task automatic test_reset_mid_op();
        int t, grants, grant_at;
        grants   = 0;
        grant_at = -1;
        set_mc(5'd12, 1'b0, 5'd10);
        t = cyc;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            advance();
            // Cycle t+1 onward: another mc op in ID plus a load-use hazard.
            set_mc(5'd13, 1'b0, 5'd2);
            ex_load_i = 1'b1;
            ex_rd_i   = 5'd12;
            id_use_i  = 3'b001;
            id_rs1_i  = 5'd12;
        end
        // Now in cycle t+2: assert reset between clock edges.
        reset_i  = 1'b0;
        m_active = 1'b0;
        m_defer  = 1'b0;
        #1;
        obs_vec = {stall_o, bubble_o, mc_start_o, mc_wb_grant_o, wb_freeze_o, mc_busy_o};
        checks++;
        if (obs_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%b exp=%b", obs_vec, 6'b0);
        end
        @(posedge clk);
        #1;
        cyc++;
        reset_i = 1'b1;
        idle_inputs();
        for (int k = 0; k < 12; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[2]) grants++;
            advance();
        end
        set_mc(5'd9, 1'b1, 5'd2);
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_relaunch k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            if (obs_vec[2]) grant_at = cyc;
            advance();
            idle_inputs();
        end
        checks++;
        if (grants !== 0 || grant_at !== t + 2) begin
            errors++;
            $display("FAIL reset_mid_summary stray_grants=%0d relaunch_grant=%0d exp 0/%0d",
                     grants, grant_at, t + 2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            id_valid_i   = ($urandom_range(0, 3) != 0);
            id_rs1_i     = 5'($urandom_range(0, 3));
            id_rs2_i     = 5'($urandom_range(0, 3));
            id_rs3_i     = 5'($urandom_range(0, 3));
            id_use_i     = 3'($urandom);
            id_bank_i    = 3'($urandom);
            id_rd_i      = 5'($urandom_range(0, 3));
            id_rd_bank_i = 1'($urandom);
            id_wb_i      = 1'($urandom);
            id_mc_op_i   = ($urandom_range(0, 3) == 0);
            id_mc_lat_i  = 5'($urandom_range(1, 6));
            ex_rd_i      = 5'($urandom_range(0, 3));
            ex_rd_bank_i = 1'($urandom);
            ex_load_i    = ($urandom_range(0, 2) == 0);
            memwb_wb_i   = 1'($urandom);
            sample();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random k=%0d got=%b exp=%b", k, obs_vec, exp_vec);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        reset_i = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_launch();
        test_raw();
        test_port_conflict();
        test_structural_waw();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
